snake_engine: RTL
=================

SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 SHALL provide parameter GRID_W, default 16, meaning playfield columns (x = 0..GRID_W-1, left to right).
REQ-002 SHALL provide parameter GRID_H, default 4, meaning playfield rows (y = 0..GRID_H-1, top to bottom).
REQ-003 SHALL provide parameter MAX_LEN, default 8, meaning maximum segment count, which is also the body storage depth.
REQ-004 SHALL provide parameter INIT_LEN, default 4, meaning length after reset, with 2 <= INIT_LEN <= MAX_LEN and INIT_LEN <= GRID_W.
REQ-005 SHALL provide parameter TICK_DIV, default 4, meaning clock cycles per move (>= 2).
REQ-006 SHALL define widths XW = clog2(GRID_W), YW = clog2(GRID_H), LW = clog2(MAX_LEN+1).
REQ-007 Port clock, input, 1: single clock; all state SHALL update on its rising edge.
REQ-008 Port reset, input, 1: asynchronous, active-high reset.
REQ-009 Port dir_valid, input, 1: requests a direction change this cycle.
REQ-010 Port dir, input, 2: requested direction: 0 up, 1 down, 2 left, 3 right.
REQ-011 Port grow, input, 1: one-cycle pulse adding one segment on the next move.
REQ-012 Port pause, input, 1: level; freezes tick counter and body while high.
REQ-013 Port q_x, input, XW, and port q_y, input, YW: occupancy query cell.
REQ-014 Port q_hit, output, 1: combinational; 1 when cell (q_x,q_y) is occupied by any live segment.
REQ-015 Port head_x, output, XW, and port head_y, output, YW: current head cell.
REQ-016 Port length, output, LW: current segment count.
REQ-017 Port heading, output, 2: current direction of travel, same encoding as dir.
REQ-018 Port alive, output, 1: 1 in RUN, 0 in DEAD.
REQ-019 Port step, output, 1: one-cycle pulse on each completed move.

Function
REQ-020 States SHALL be RUN and DEAD only; pause is a qualifier of RUN and not a separate state.
REQ-021 Tick counter SHALL count 0..TICK_DIV-1 in RUN with pause low; the move cycle is the cycle in which the count equals TICK_DIV-1, and the counter SHALL then wrap to 0.
REQ-022 dir_valid SHALL latch dir into pending_dir; the last request before a move cycle wins, and a request in the move cycle itself SHALL apply to the following move.
REQ-023 At the move cycle, pending_dir SHALL become heading unless it is the exact reverse of heading (up/down, left/right), in which case it SHALL be discarded.
REQ-024 grow SHALL set a sticky grow_pending flag, cleared at the next move; multiple pulses between moves SHALL count as one.
REQ-025 New head = head stepped one cell in heading; wall collision SHALL occur when the step would leave 0..GRID_W-1 or 0..GRID_H-1.
REQ-026 Self collision SHALL occur when the new head equals any segment 0..length-1, except the tail segment when no growth occurs this move.
REQ-027 On a collision, the block SHALL enter DEAD, leave the body, head and length unchanged, and not assert step.
REQ-028 On a legal move, segments SHALL shift (seg[i] <= seg[i-1]), seg[0] SHALL take the new head, and step SHALL be 1 for exactly one cycle.
REQ-029 On growth, length SHALL increase by 1 if length < MAX_LEN and otherwise saturate at MAX_LEN; the old tail SHALL be retained when length increases.
REQ-030 DEAD SHALL be absorbing: tick counter frozen, dir/grow/pause ignored, outputs held; only reset exits.
REQ-031 q_hit SHALL compare only indices < length; storage beyond length is don't-care and SHALL never hit.

Reset
REQ-032 Reset SHALL set seg[i] = (INIT_LEN-1-i, 0), length = INIT_LEN, heading = pending_dir = 3 (right), alive = 1, step = 0, tick = 0, grow_pending = 0, and state RUN.
REQ-033 Reset asserted mid-move or in DEAD SHALL restore REQ-032 values immediately and asynchronously, with no spurious step after release.

Verification
REQ-034 Defaults, release reset, no input -> step every 4 cycles; head_x 3,4,...,15 after 12 steps; the 13th move cycle -> alive=0, head_x holds 15, no step.
REQ-035 Heading right, dir=2 (left) pulse -> ignored, head_x keeps incrementing; dir=1 -> next move head=(4,1), heading=1.
REQ-036 grow pulsed before 5 moves -> length 5,6,7,8,8; tail cell retained on each growing move; q_hit true at (0,0) after the first growth.
REQ-037 grow once (head (4,0), length 5), then down, left, up -> head would enter (3,0) -> alive=0, length=5.
REQ-038 Length 4, down, left, up -> head enters vacated tail (2,0) -> legal move, alive=1, step asserted.
REQ-039 pause high for 10 cycles -> no step, tick frozen; reset asserted mid-tick -> head (3,0), length 4, alive 1 on the same edge.

Source files
------------

// File: rtl/snake_engine.sv
// snake_engine: grid snake game core.
//   A tick counter paces moves (one move every TICK_DIV cycles while running
//   and not paused). Each move steps the head one cell in the current heading,
//   shifts the body and optionally grows. A wall or self collision drops the
//   block into DEAD, which only reset leaves.
// Ports:
//   clock, reset        : single clock, asynchronous active-high reset
//   dir_valid, dir      : direction request (0 up, 1 down, 2 left, 3 right)
//   grow                : pulse, adds one segment on the next move
//   pause               : level, freezes tick counter and body
//   q_x, q_y -> q_hit   : combinational occupancy query of one cell
//   head_x, head_y      : current head cell
//   length, heading     : segment count, direction of travel
//   alive, step         : RUN indicator, one-cycle pulse per completed move
module snake_engine #(
  parameter int GRID_W   = 16,
  parameter int GRID_H   = 4,
  parameter int MAX_LEN  = 8,
  parameter int INIT_LEN = 4,
  parameter int TICK_DIV = 4,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          dir_valid,
  input  logic [1:0]    dir,
  input  logic          grow,
  input  logic          pause,
  input  logic [XW-1:0] q_x,
  input  logic [YW-1:0] q_y,
  output logic          q_hit,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [LW-1:0] length,
  output logic [1:0]    heading,
  output logic          alive,
  output logic          step
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_DEAD = 1'b1;

  localparam logic [1:0] D_UP    = 2'd0;
  localparam logic [1:0] D_DOWN  = 2'd1;
  localparam logic [1:0] D_LEFT  = 2'd2;
  localparam logic [1:0] D_RIGHT = 2'd3;

  logic [MAX_LEN-1:0][XW-1:0] seg_x_q, seg_x_d;
  logic [MAX_LEN-1:0][YW-1:0] seg_y_q, seg_y_d;
  logic [LW-1:0]              len_q, len_d;
  logic [1:0]                 hd_q, hd_d;
  logic [1:0]                 pend_q, pend_d;
  logic                       grow_q, grow_d;
  logic [TW-1:0]              tick_q, tick_d;
  logic [0:0]                 state_q, state_d;
  logic                       step_q, step_d;

  // Move datapath
  logic          move;
  logic [1:0]    new_hd;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic          wall;
  logic          self_hit;
  logic          grows;

  assign move = (state_q == S_RUN) && !pause && (tick_q == TW'(TICK_DIV - 1));

  // Same-axis directions differ only in bit 0, so XOR == 01 marks a reversal.
  assign new_hd = ((pend_q ^ hd_q) == 2'b01) ? hd_q : pend_q;

  // Length only increases below MAX_LEN; at saturation the tail still leaves.
  assign grows = grow_q && (len_q < LW'(MAX_LEN));

  always_comb begin
    nx   = seg_x_q[0];
    ny   = seg_y_q[0];
    wall = 1'b0;
    case (new_hd)
      D_UP:    if (seg_y_q[0] == '0) wall = 1'b1; else ny = seg_y_q[0] - YW'(1);
      D_DOWN:  if (seg_y_q[0] == YW'(GRID_H - 1)) wall = 1'b1; else ny = seg_y_q[0] + YW'(1);
      D_LEFT:  if (seg_x_q[0] == '0) wall = 1'b1; else nx = seg_x_q[0] - XW'(1);
      default: if (seg_x_q[0] == XW'(GRID_W - 1)) wall = 1'b1; else nx = seg_x_q[0] + XW'(1);
    endcase
  end

  // The tail cell is vacated during this move unless the length grows.
  always_comb begin
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LW'(i) < len_q) && (seg_x_q[i] == nx) && (seg_y_q[i] == ny) &&
          !((LW'(i) == len_q - LW'(1)) && !grows))
        self_hit = 1'b1;
    end
  end

  always_comb begin
    seg_x_d = seg_x_q;
    seg_y_d = seg_y_q;
    len_d   = len_q;
    hd_d    = hd_q;
    pend_d  = pend_q;
    grow_d  = grow_q;
    tick_d  = tick_q;
    state_d = state_q;
    step_d  = 1'b0;
    if (state_q == S_RUN) begin
      if (dir_valid) pend_d = dir;
      if (grow)      grow_d = 1'b1;
      if (!pause) begin
        tick_d = move ? '0 : tick_q + TW'(1);
        if (move) begin
          hd_d   = new_hd;
          // A grow pulse landing on the move cycle belongs to the next move.
          grow_d = grow;
          if (wall || self_hit) begin
            state_d = S_DEAD;
          end else begin
            for (int i = MAX_LEN - 1; i > 0; i--) begin
              seg_x_d[i] = seg_x_q[i-1];
              seg_y_d[i] = seg_y_q[i-1];
            end
            seg_x_d[0] = nx;
            seg_y_d[0] = ny;
            if (grows) len_d = len_q + LW'(1);
            step_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= (i < INIT_LEN) ? XW'(INIT_LEN - 1 - i) : '0;
        seg_y_q[i] <= '0;
      end
      len_q   <= LW'(INIT_LEN);
      hd_q    <= D_RIGHT;
      pend_q  <= D_RIGHT;
      grow_q  <= 1'b0;
      tick_q  <= '0;
      state_q <= S_RUN;
      step_q  <= 1'b0;
    end else begin
      seg_x_q <= seg_x_d;
      seg_y_q <= seg_y_d;
      len_q   <= len_d;
      hd_q    <= hd_d;
      pend_q  <= pend_d;
      grow_q  <= grow_d;
      tick_q  <= tick_d;
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    q_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LW'(i) < len_q) && (seg_x_q[i] == q_x) && (seg_y_q[i] == q_y))
        q_hit = 1'b1;
    end
  end

  assign head_x  = seg_x_q[0];
  assign head_y  = seg_y_q[0];
  assign length  = len_q;
  assign heading = hd_q;
  assign alive   = (state_q == S_RUN);
  assign step    = step_q;

endmodule
